// File: rtl/digi_ota_array.sv
// rtl/digi_ota_array.sv - multi-channel clocked digital OTA with debounce, hold release and transition counters
// Optional per-channel transition counters are built when DIGI_OTA_CNT_EN is defined.
module digi_ota_array #(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 3,
    parameter int HOLD_CYCLES = 15,
    parameter int CW          = 8,
    localparam int SELW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N_CH-1:0] vip,
    input  logic [N_CH-1:0] vin,
    output logic [N_CH-1:0] out_val,
    output logic [N_CH-1:0] out_oe,
    output logic [N_CH-1:0] chg,
    input  logic [SELW-1:0] cnt_sel,
    input  logic            cnt_clr,
    output logic [CW-1:0]   cnt_q
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRV_H = 2'd1,
        DRV_L = 2'd2
    } drv_state_t;

    localparam logic [7:0] DEB_L  = 8'(DEB_CYCLES);
    localparam logic [7:0] HOLD_L = 8'(HOLD_CYCLES);

    logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync_p;
    logic [SYNC_STAGES-1:0][N_CH-1:0] r_sync_n;
    logic [N_CH-1:0] w_s_vip;
    logic [N_CH-1:0] w_s_vin;

    drv_state_t      r_state     [N_CH];
    drv_state_t      w_nxt_state [N_CH];
    logic [N_CH-1:0] r_tgt;
    logic [N_CH-1:0] w_nxt_tgt;
    logic [7:0]      r_dcnt      [N_CH];
    logic [7:0]      w_nxt_dcnt  [N_CH];
    logic [7:0]      r_hcnt      [N_CH];
    logic [7:0]      w_nxt_hcnt  [N_CH];
    logic [N_CH-1:0] w_nxt_oe;
    logic [N_CH-1:0] w_nxt_val;
    logic [N_CH-1:0] w_chg;
    logic [N_CH-1:0] w_entry;
    logic [N_CH-1:0] r_out_val;
    logic [N_CH-1:0] r_out_oe;
    logic [N_CH-1:0] r_chg;
    logic [CW-1:0]   w_cnt_q;

    // Synchronisers only honour rst_n; they keep sampling while ena is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync_p <= '0;
            r_sync_n <= '0;
        end else begin
            r_sync_p <= {r_sync_p[SYNC_STAGES-2:0], vip};
            r_sync_n <= {r_sync_n[SYNC_STAGES-2:0], vin};
        end
    end

    assign w_s_vip = r_sync_p[SYNC_STAGES-1];
    assign w_s_vin = r_sync_n[SYNC_STAGES-1];

    always_comb begin
        w_nxt_tgt = r_tgt;
        w_nxt_oe  = '0;
        w_nxt_val = '0;
        w_chg     = '0;
        w_entry   = '0;
        for (int i = 0; i < N_CH; i++) begin
            logic       v_dec;
            logic       v_dir;
            logic       v_same;
            logic [7:0] v_run;
            w_nxt_state[i] = r_state[i];
            w_nxt_dcnt[i]  = r_dcnt[i];
            w_nxt_hcnt[i]  = r_hcnt[i];
            v_dec  = w_s_vip[i] ^ w_s_vin[i];
            v_dir  = w_s_vip[i];
            v_same = (r_state[i] == DRV_H && v_dir) || (r_state[i] == DRV_L && !v_dir);
            v_run  = 8'd1;
            if (v_dec) begin
                w_nxt_hcnt[i] = 8'd0;
                if (v_same) begin
                    w_nxt_tgt[i]  = 1'b0;
                    w_nxt_dcnt[i] = 8'd0;
                end else begin
                    if (r_dcnt[i] != 8'd0 && r_tgt[i] == v_dir)
                        v_run = r_dcnt[i] + 8'd1;
                    if (v_run == DEB_L) begin
                        w_nxt_state[i] = v_dir ? DRV_H : DRV_L;
                        w_nxt_tgt[i]   = 1'b0;
                        w_nxt_dcnt[i]  = 8'd0;
                        w_entry[i]     = 1'b1;
                    end else begin
                        w_nxt_tgt[i]  = v_dir;
                        w_nxt_dcnt[i] = v_run;
                    end
                end
            end else begin
                w_nxt_tgt[i]  = 1'b0;
                w_nxt_dcnt[i] = 8'd0;
                // HOLD_CYCLES of 0 disables release, so the hold counter stays idle.
                if (r_state[i] == IDLE || HOLD_L == 8'd0) begin
                    w_nxt_hcnt[i] = 8'd0;
                end else if (r_hcnt[i] + 8'd1 == HOLD_L) begin
                    w_nxt_state[i] = IDLE;
                    w_nxt_hcnt[i]  = 8'd0;
                end else begin
                    w_nxt_hcnt[i] = r_hcnt[i] + 8'd1;
                end
            end
            w_nxt_oe[i]  = (w_nxt_state[i] != IDLE);
            w_nxt_val[i] = (w_nxt_state[i] == DRV_H) ? 1'b1 :
                           (w_nxt_state[i] == DRV_L) ? 1'b0 : r_out_val[i];
            w_chg[i]     = (w_nxt_oe[i] != r_out_oe[i]) || (w_nxt_val[i] != r_out_val[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || !ena) begin
            r_tgt     <= '0;
            r_out_val <= '0;
            r_out_oe  <= '0;
            r_chg     <= '0;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= IDLE;
                r_dcnt[i]  <= 8'd0;
                r_hcnt[i]  <= 8'd0;
            end
        end else begin
            r_tgt     <= w_nxt_tgt;
            r_out_val <= w_nxt_val;
            r_out_oe  <= w_nxt_oe;
            r_chg     <= w_chg;
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_nxt_state[i];
                r_dcnt[i]  <= w_nxt_dcnt[i];
                r_hcnt[i]  <= w_nxt_hcnt[i];
            end
        end
    end

`ifdef DIGI_OTA_CNT_EN
    logic [CW-1:0] r_cnt [N_CH];

    always_ff @(posedge clk) begin
        if (!rst_n || !ena || cnt_clr) begin
            for (int i = 0; i < N_CH; i++)
                r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++)
                if (w_entry[i] && r_cnt[i] != {CW{1'b1}})
                    r_cnt[i] <= r_cnt[i] + CW'(1);
        end
    end

    // Selecting by comparison keeps an out-of-range cnt_sel at zero.
    always_comb begin
        w_cnt_q = '0;
        for (int i = 0; i < N_CH; i++)
            if (cnt_sel == SELW'(i))
                w_cnt_q = r_cnt[i];
    end
`else
    logic w_unused;
    assign w_unused = ^{cnt_sel, cnt_clr, w_entry};
    assign w_cnt_q  = '0;
`endif

    assign out_val = r_out_val;
    assign out_oe  = r_out_oe;
    assign chg     = r_chg;
    assign cnt_q   = w_cnt_q;

endmodule

// File: doc/digi_ota_array.md
Name: digi_ota_array

Overview:
- Clocked, multi-channel successor to the single-channel gate-level digital OTA cell.
- Each channel compares a digital differential pair (vip/vin) and drives a tri-state-style output (value plus output enable) high or low.
- Drive direction changes only after the new direction has persisted for DEB_CYCLES samples; the output is released (oe=0) after HOLD_CYCLES of balanced input.
- Sits between the chip pin inputs and the pad/analog output mux; one instance serves all channels.

Parameters:
- N_CH, 4, number of independent channels (1..8).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- DEB_CYCLES, 3, consecutive identical decisions required to change drive (1..255).
- HOLD_CYCLES, 15, consecutive balanced samples before release; 0 = never release (1..255 otherwise).
- CW, 8, width of the optional per-channel transition counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- ena  in  1  block enable; 0 = synchronous clear of all state except the synchronisers.
- vip  in  N_CH  positive inputs, asynchronous.
- vin  in  N_CH  negative inputs, asynchronous.
- out_val  out  N_CH  driven value per channel.
- out_oe  out  N_CH  output enable per channel (1 = driving).
- chg  out  N_CH  one-cycle pulse when out_val or out_oe of a channel changes.
- cnt_sel  in  max(1,$clog2(N_CH))  counter readback channel select.
- cnt_clr  in  1  synchronous clear of all counters.
- cnt_q  out  CW  selected channel's transition count.

Behaviour:
- Reset: rst_n sampled low at a clk edge clears state; all synchroniser flops, out_val, out_oe, chg, counters and trackers = 0. Reset overrides ena and all other inputs, including mid-debounce and mid-hold.
- Synchroniser: vip/vin pass through SYNC_STAGES flops to give s_vip/s_vin.
- Decision per channel:
  - UP = s_vip & ~s_vin.
  - DN = ~s_vip & s_vin.
  - EQ otherwise.
- Drive state per channel: IDLE (oe=0), DRV_H (oe=1, val=1), DRV_L (oe=1, val=0). out_val and out_oe are registered directly from the state; out_val holds its last value in IDLE.
- Debounce tracker per channel: target direction plus dcnt.
  - Decision UP/DN that differs from the current drive (any direction while in IDLE): if it equals the target, dcnt increments; otherwise target is set to it and dcnt=1.
  - When dcnt reaches DEB_CYCLES, the state moves to DRV_H/DRV_L at that edge and the tracker clears.
  - Decision equal to the current drive direction, or EQ: tracker clears.
  - An aborted pending change leaves the drive state untouched; a glitch shorter than DEB_CYCLES never affects the outputs.
- Latency: a stable input change applied before edge 1 is visible on the outputs after edge SYNC_STAGES+DEB_CYCLES.
- Hold counter (DRV_H/DRV_L only):
  - Counts consecutive EQ decisions; any UP/DN clears it.
  - Reaching HOLD_CYCLES moves the state to IDLE at that edge.
  - An opposite direction pending during EQ is impossible, because EQ clears the tracker.
- chg: registered; high for exactly the cycle in which the new out_val/out_oe first appear.
- ena=0: state returns to IDLE with val=0 and trackers clear, matching reset; chg stays 0; synchronisers keep sampling. On ena rising, normal operation resumes from IDLE.
- Channels are fully independent; simultaneous events on different channels are all honoured in the same cycle.

Optional Feature:
- Macro: DIGI_OTA_CNT_EN.
- Defined:
  - Per-channel CW-bit saturating counter increments on every entry into DRV_H or DRV_L. Release to IDLE does not count.
  - Counters hold at 2^CW-1.
  - cnt_clr clears all counters; if an increment coincides with cnt_clr, clear wins.
  - cnt_q = counter[cnt_sel], combinational. An out-of-range cnt_sel returns 0.
- Not defined: no counter logic; cnt_q tied 0; cnt_sel and cnt_clr ignored. The ports remain present.

Test Plan:
All scenarios use N_CH=4, SYNC_STAGES=2, DEB_CYCLES=3, HOLD_CYCLES=15.
1. Hold rst_n=0 for 3 edges with random vip/vin -> out_val=0, out_oe=0, chg=0, cnt_q=0. Assert rst_n mid-pending on ch1 -> ch1 remains IDLE.
2. ch0 vip=1, vin=0 set before edge 1 -> out_oe[0]=1 and out_val[0]=1 after edge 5, not after edge 4. chg[0]=1 only in the cycle after edge 5. Other channels unchanged.
3. ch0 in DRV_H, 2-cycle DN glitch -> no output change, chg[0]=0. A 3-cycle-or-longer DN (synchronised) -> DRV_L after its 3rd synchronised sample, chg pulse.
4. ch2 in DRV_L, vip=vin=1 for 14 synchronised cycles then DN -> oe stays 1. Then 15 EQ cycles -> out_oe[2]=0 after the 15th, out_val[2] stays 0, one chg pulse.
5. ch3 driving, ena=0 for 1 cycle -> out_oe[3]=0, out_val[3]=0 next cycle. After ena=1 with UP held -> DRV_H after 3 edges.
6. With DIGI_OTA_CNT_EN and CW=4: alternate ch1 UP/DN (4 cycles each) for 20 entries -> cnt_sel=1 gives cnt_q=15. Pulse cnt_clr -> 0. Without the macro -> cnt_q=0 throughout.
